// File: rtl/spk_write_packer_pkg.sv
// rtl/spk_write_packer_pkg.sv - shared spike-memory constants and packer FSM states
package spk_write_packer_pkg;

    localparam int SPK_SLOTS  = 8;
    localparam int SPK_BITS   = 2;
    localparam int SPK_SLOT_W = 3;
    localparam int SPK_WORD_W = SPK_SLOTS * SPK_BITS;
    localparam int SPK_ADDR_W = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PACK  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/spk_write_packer.sv
// rtl/spk_write_packer.sv - packs 2-bit spike values into 16-bit words and writes them to the spike SRAM
module spk_write_packer
    import spk_write_packer_pkg::*;
#(
    parameter logic [SPK_ADDR_W-1:0] BASE_ADDR   = 9'd0,
    parameter int                    FRAME_WORDS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [SPK_BITS-1:0]   in_spk,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [SPK_WORD_W-1:0] spk_write_in,
    output logic [SPK_ADDR_W-1:0] cntrl_spk_write_addr,
    output logic                  cntrl_spk_write_we,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [SPK_ADDR_W-1:0] LAST_ADDR =
        SPK_ADDR_W'(int'(BASE_ADDR) + FRAME_WORDS - 1);

    generate
        if (FRAME_WORDS < 1 || FRAME_WORDS > 512 ||
            int'(BASE_ADDR) + FRAME_WORDS - 1 > 511) begin : g_bad_frame
            $error("spk_write_packer: frame does not fit in the 9-bit spike SRAM");
        end
    endgenerate

    logic [1:0]            state;
    logic [SPK_SLOT_W-1:0] slot;
    logic [SPK_WORD_W-1:0] word;
    logic [SPK_ADDR_W-1:0] addr;
    logic                  closed_by_last;
    logic                  we;
    logic                  done_q;
    logic                  ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            slot           <= '0;
            word           <= '0;
            addr           <= BASE_ADDR;
            closed_by_last <= 1'b0;
            we             <= 1'b0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            we     <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_PACK;
                        addr  <= BASE_ADDR;
                        slot  <= '0;
                        word  <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                ST_PACK: begin
                    if (in_valid) begin
                        word[slot*SPK_BITS +: SPK_BITS] <= in_spk;
                        slot <= slot + 1'b1;
                        // Strobe is registered so it lines up with the WRITE state exactly.
                        if (slot == SPK_SLOT_W'(SPK_SLOTS - 1) || in_last) begin
                            state          <= ST_WRITE;
                            we             <= 1'b1;
                            closed_by_last <= in_last;
                        end
                    end
                end
                ST_WRITE: begin
                    if (addr == LAST_ADDR) begin
                        addr <= BASE_ADDR;
                        if (!closed_by_last) begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        addr <= addr + 1'b1;
                    end
                    word <= '0;
                    slot <= '0;
                    if (closed_by_last) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        state <= ST_PACK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready             = (state == ST_PACK);
    assign spk_write_in         = word;
    assign cntrl_spk_write_addr = addr;
    assign cntrl_spk_write_we   = we;
    assign done                 = done_q;
    assign overflow             = ovf_q;

endmodule

// File: tb/tb_spk_write_packer.sv
// tb/tb_spk_write_packer.sv - randomized and directed checks of spk_write_packer against a frame-level model
module tb_spk_write_packer;

    localparam logic [8:0] BASE = 9'd6;
    localparam int         FW   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_spk = 2'd0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] spk_write_in;
    logic [8:0]  cntrl_spk_write_addr;
    logic        cntrl_spk_write_we;
    logic        done;
    logic        overflow;

    spk_write_packer #(.BASE_ADDR(BASE), .FRAME_WORDS(FW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .in_valid             (in_valid),
        .in_spk               (in_spk),
        .in_last              (in_last),
        .in_ready             (in_ready),
        .spk_write_in         (spk_write_in),
        .cntrl_spk_write_addr (cntrl_spk_write_addr),
        .cntrl_spk_write_we   (cntrl_spk_write_we),
        .done                 (done),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0]  got_addr[$];
    logic [15:0] got_data[$];
    int          got_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;

    logic [1:0]  vals[$];
    logic [8:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cntrl_spk_write_we) begin
            got_addr.push_back(cntrl_spk_write_addr);
            got_data.push_back(spk_write_in);
            got_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Frame model: values fill 8 two-bit slots LSB first; a word closes when full or on the last value.
    task automatic model(output bit ovf);
        logic [15:0] w;
        int sl;
        exp_addr.delete();
        exp_data.delete();
        w  = '0;
        sl = 0;
        for (int i = 0; i < vals.size(); i++) begin
            w = w | (16'(vals[i]) << (2 * sl));
            sl++;
            if (sl == 8 || i == vals.size() - 1) begin
                exp_data.push_back(w);
                w  = '0;
                sl = 0;
            end
        end
        for (int k = 0; k < exp_data.size(); k++)
            exp_addr.push_back(9'(int'(BASE) + (k % FW)));
        ovf = (exp_data.size() > FW);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"},    32'(cntrl_spk_write_we), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_data"},  32'(spk_write_in), 32'd0);
        chk({tag, "_addr"},  32'(cntrl_spk_write_addr), 32'(BASE));
    endtask

    task automatic run_frame(input string tag, input int gap_idx, input int gap_len,
                             input int start_idx, input int abort_n, input bit rgap);
        int i, sl, gap, budget, n, lim;
        bit gap_done, st_done;
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        exp_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_ovf_after_start"}, 32'(overflow), 32'd0);
        chk({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
        n = vals.size();
        lim = (abort_n > 0) ? abort_n : n;
        i = 0; sl = 0; gap = 0; budget = 3000;
        gap_done = 1'b0; st_done = 1'b0;
        while (i < lim && budget > 0) begin
            start = 1'b0;
            if (i == start_idx && !st_done && in_ready) begin
                start   = 1'b1;
                st_done = 1'b1;
            end
            if (i == gap_idx && !gap_done) begin
                gap      = gap_len;
                gap_done = 1'b1;
            end
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid = rgap ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            in_spk  = vals[i];
            in_last = (i == n - 1);
            if (in_valid && in_ready) begin
                sl++;
                if (sl == 8 || in_last) begin
                    exp_cyc.push_back(cyc + 1);
                    sl = 0;
                end
                i++;
            end
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        chk({tag, "_drive_budget"}, 32'(budget > 0), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        bit ovf;
        int waited;
        waited = 0;
        while (done_cnt == 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) @(negedge clk);
        model(ovf);
        chk({tag, "_nwrites"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(got_addr[k]), 32'(exp_addr[k]));
            chk($sformatf("%s_data%0d", tag, k), 32'(got_data[k]), 32'(exp_data[k]));
            if (k < exp_cyc.size())
                chk($sformatf("%s_lat%0d", tag, k), 32'(got_cyc[k]), 32'(exp_cyc[k]));
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (exp_cyc.size() > 0)
            chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_cyc[exp_cyc.size()-1] + 1));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        vals = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        run_frame("full8", -1, 0, -1, 0, 1'b0);
        check_frame("full8");
        if (got_data.size() > 0) chk("full8_const", 32'(got_data[0]), 32'h3939);

        vals = '{2'd3, 2'd3, 2'd3};
        run_frame("part3", -1, 0, -1, 0, 1'b0);
        check_frame("part3");
        if (got_data.size() > 0) chk("part3_const", 32'(got_data[0]), 32'h003f);

        vals.delete();
        repeat (24) vals.push_back(2'd1);
        run_frame("wrap24", -1, 0, -1, 0, 1'b0);
        check_frame("wrap24");
        chk("wrap24_ovf_const", 32'(overflow), 32'd1);
        if (got_addr.size() == 3) begin
            chk("wrap24_a2", 32'(got_addr[2]), 32'(BASE));
            chk("wrap24_d2", 32'(got_data[2]), 32'h5555);
        end

        vals.delete();
        repeat (12) vals.push_back(2'($urandom_range(0, 3)));
        run_frame("gap", 3, 5, -1, 0, 1'b0);
        check_frame("gap");

        vals.delete();
        repeat (10) vals.push_back(2'($urandom_range(0, 3)));
        run_frame("midstart", -1, 0, 4, 0, 1'b0);
        check_frame("midstart");

        vals.delete();
        repeat (10) vals.push_back(2'($urandom_range(0, 3)));
        run_frame("abort", -1, 0, -1, 4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort_rst");
        repeat (3) @(negedge clk);
        chk("abort_no_we", 32'(got_data.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        vals = '{2'd2, 2'd1};
        run_frame("after_rst", -1, 0, -1, 0, 1'b0);
        check_frame("after_rst");

        for (int f = 0; f < 6; f++) begin
            vals.delete();
            repeat ($urandom_range(1, 30)) vals.push_back(2'($urandom_range(0, 3)));
            run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 4)), -1, 0, 1'b1);
            check_frame($sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spk_write_packer.md
SPK_WRITE_PACKER -- requirements
Module: spk_write_packer

Interface
REQ-001 Parameter BASE_ADDR, default 9'd0: first SRAM word address of the spike frame.
REQ-002 Parameter FRAME_WORDS, default 32: number of 16-bit words per frame (1..512).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that opens a new frame; honoured only in IDLE.
REQ-006 in_valid  input  1  an upstream 2-bit spike value is present.
REQ-007 in_spk  input  2  spike value for the current neuron.
REQ-008 in_last  input  1  qualifies in_valid; marks the final neuron of the frame.
REQ-009 in_ready  output  1  packer accepts in_spk this cycle.
REQ-010 spk_write_in  output  16  packed word, driven to the memory controller's spike-write data input.
REQ-011 cntrl_spk_write_addr  output  9  SRAM word address.
REQ-012 cntrl_spk_write_we  output  1  one-cycle write strobe.
REQ-013 done  output  1  one-cycle pulse after the frame's final word is written.
REQ-014 overflow  output  1  sticky flag: more than FRAME_WORDS words were written in one frame.

Function
REQ-015 Transfer occurs on a cycle where in_valid && in_ready.
REQ-016 States: IDLE, PACK, WRITE.
- IDLE: in_ready=0; start -> PACK, addr=BASE_ADDR, slot=0, overflow cleared.
- PACK: in_ready=1.
- WRITE: in_ready=0; we=1 for exactly one cycle.
REQ-017 Slot k (0..7) of the word SHALL hold in_spk in bits [2k+1:2k], so that a reader using a 3-bit slot select k recovers it.
REQ-018 On a transfer in PACK, the value is stored in the current slot and the slot increments; the state goes to WRITE when the stored slot was 7 or in_last=1.
- Unfilled slots of a word closed by in_last SHALL be 2'b00.
REQ-019 In WRITE, spk_write_in and cntrl_spk_write_addr SHALL be stable for the strobe cycle.
- Latency: transfer at cycle N -> we=1 at cycle N+1.
REQ-020 After the WRITE cycle: the address increments, the slot register is zeroed and slot=0.
- If the word was closed by in_last, done=1 in the same cycle as the return to IDLE (cycle N+2); otherwise -> PACK.
REQ-021 Address wrap: the increment after writing BASE_ADDR+FRAME_WORDS-1 SHALL return the address to BASE_ADDR.
- If that word was not closed by in_last, overflow SHALL be set and remain set until the next accepted start or reset.
REQ-022 start outside IDLE SHALL be ignored; in_valid in IDLE or WRITE is not consumed.
REQ-023 Address arithmetic is 9-bit modulo 512; BASE_ADDR+FRAME_WORDS-1 SHALL not exceed 511 (elaboration-time check).

Reset
REQ-024 When rst=1 at a clock edge: state=IDLE, slot=0, packed word=0, addr=BASE_ADDR, in_ready=0, cntrl_spk_write_we=0, done=0, overflow=0, spk_write_in=0.
REQ-025 Reset mid-frame SHALL discard a partial word with no write strobe.
- A WRITE cycle coinciding with rst SHALL not assert we.

Structure
REQ-026 Shared package: the SPK_SLOTS=8 and SPK_BITS=2 constants, the state enumeration, and the 9-bit SRAM address width, shared with the spike memory controller.
REQ-027 No sub-module is required; the implementation is a single FSM with a slot counter and an address counter.

Verification
REQ-028 start; 8 transfers of values 1,2,3,0,1,2,3,0 with in_last on the 8th -> one we at addr 0, data 16'h3939, done one cycle later.
REQ-029 start; 3 transfers 3,3,3 with in_last on the 3rd -> we with data 16'h003F at addr 0; no further we.
REQ-030 FRAME_WORDS=2; start; 24 transfers of value 1, in_last on the 24th -> writes 16'h5555 at addrs 0, 1, 0; overflow=1; done pulses once.
REQ-031 in_valid held low in PACK for 5 cycles mid-word -> no we; the slot position is retained; packing resumes correctly.
REQ-032 rst asserted on the cycle after the 4th transfer -> no we ever issued; all outputs at reset values; the next start begins at BASE_ADDR, slot 0.
REQ-033 start pulsed during PACK -> ignored; addr and slot unchanged.
